// File: rtl/link_control.sv
// link_control: per-frame sequencing FSM for the player character datapath, collision detector and map drawer.
// Optional feature: define LINK_CONTROL_WATCHDOG_EN for per-state timeouts and a sticky watchdog_fired output.
module link_control #(
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned CNT_W        = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        collision_done,
  input  logic        map_draw_done,
  input  logic        link_draw_done,
  input  logic [2:0]  hp,
  output logic        init,
  output logic        idle,
  output logic        reg_action,
  output logic        check_collision,
  output logic        apply_action,
  output logic        draw_map,
  output logic        draw,
  output logic        game_over,
  output logic        frame_overrun,
`ifdef LINK_CONTROL_WATCHDOG_EN
  output logic        watchdog_fired,
`endif
  output logic [15:0] frame_count
);

  typedef enum logic [3:0] {
    S_INIT, S_WAIT, S_IDLE, S_REG, S_COLLIDE,
    S_APPLY, S_DRAW_MAP, S_DRAW_LINK, S_OVER
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             wd_timeout;
  logic             busy;

  // Frame pacing runs independently of the FSM so frame boundaries stay periodic.
  assign tick = (tick_cnt == LAST);

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

`ifdef LINK_CONTROL_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_fire;

  // Dwell counter restarts whenever the FSM changes state.
  always_ff @(posedge clock) begin
    if (reset || state_next != state) wd_cnt <= '0;
    else                              wd_cnt <= wd_cnt + CNT_W'(1);
  end

  assign wd_timeout = (wd_cnt == LAST);
  assign wd_fire    = wd_timeout &&
                      ((state == S_COLLIDE   && !collision_done) ||
                       (state == S_DRAW_MAP  && !map_draw_done)  ||
                       (state == S_DRAW_LINK && !link_draw_done));

  always_ff @(posedge clock) begin
    if (reset || state == S_INIT) watchdog_fired <= 1'b0;
    else if (wd_fire)             watchdog_fired <= 1'b1;
  end
`else
  assign wd_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_INIT:      state_next = S_WAIT;
      S_WAIT:      if (start) state_next = S_IDLE;
      S_IDLE:      if (tick) state_next = S_REG;
      S_REG:       state_next = S_COLLIDE;
      S_COLLIDE:   if (collision_done || wd_timeout) state_next = S_APPLY;
      S_APPLY:     state_next = (hp == 3'd0) ? S_OVER : S_DRAW_MAP;
      S_DRAW_MAP:  if (map_draw_done || wd_timeout) state_next = S_DRAW_LINK;
      S_DRAW_LINK: if (link_draw_done || wd_timeout) state_next = S_IDLE;
      S_OVER:      if (start) state_next = S_INIT;
      default:     state_next = S_INIT;
    endcase
  end

  // A tick is only expected while idle; outside IDLE/WAIT/OVER it is dropped and flagged.
  assign busy = !(state inside {S_IDLE, S_WAIT, S_OVER});

  always_ff @(posedge clock) begin
    if (reset || state == S_INIT) begin
      frame_overrun <= 1'b0;
      frame_count   <= '0;
    end else begin
      if (tick && busy) frame_overrun <= 1'b1;
      if (state == S_DRAW_LINK && state_next == S_IDLE) frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    {init, idle, reg_action, check_collision, apply_action, draw_map, draw, game_over} = '0;
    case (state)
      S_INIT:      init            = 1'b1;
      S_IDLE:      idle            = 1'b1;
      S_REG:       reg_action      = 1'b1;
      S_COLLIDE:   check_collision = 1'b1;
      S_APPLY:     apply_action    = 1'b1;
      S_DRAW_MAP:  draw_map        = 1'b1;
      S_DRAW_LINK: draw            = 1'b1;
      S_OVER:      game_over       = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_link_control.sv
// Randomized bench for link_control against a phase-level reference model; FRAME_CYCLES=32.
// Define LINK_CONTROL_WATCHDOG_EN for both bench and RTL to exercise the watchdog.
module tb_link_control;
  localparam int FC = 32;
`ifdef LINK_CONTROL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, collision_done = 1'b0, map_draw_done = 1'b0, link_draw_done = 1'b0;
  logic [2:0]  hp = 3'd1;
  logic        init, idle, reg_action, check_collision, apply_action, draw_map, draw, game_over;
  logic        frame_overrun;
  logic [15:0] frame_count;
`ifdef LINK_CONTROL_WATCHDOG_EN
  logic        watchdog_fired;
`endif

  link_control #(.FRAME_CYCLES(FC), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .start(start),
    .collision_done(collision_done), .map_draw_done(map_draw_done),
    .link_draw_done(link_draw_done), .hp(hp),
    .init(init), .idle(idle), .reg_action(reg_action),
    .check_collision(check_collision), .apply_action(apply_action),
    .draw_map(draw_map), .draw(draw), .game_over(game_over),
    .frame_overrun(frame_overrun),
`ifdef LINK_CONTROL_WATCHDOG_EN
    .watchdog_fired(watchdog_fired),
`endif
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: game phases, frame ticks from elapsed cycles since reset.
  typedef enum {P_INIT, P_WAIT, P_IDLE, P_REG, P_COLLIDE, P_APPLY, P_MAP, P_LINK, P_OVER} phase_t;
  phase_t      m_st = P_INIT;
  int          m_cyc = 0;
  int          m_dwell = 0;
  bit          m_ovr = 1'b0;
  bit          m_wdf = 1'b0;
  logic [15:0] m_fc = '0;

  task automatic model_edge();
    phase_t nx;
    bit     tick, tmo, fired;
    if (reset) begin
      m_st = P_INIT; m_cyc = 0; m_dwell = 0; m_ovr = 0; m_wdf = 0; m_fc = '0;
      return;
    end
    tick  = (m_cyc % FC) == FC - 1;
    m_cyc++;
    tmo   = WD && (m_dwell == FC - 1);
    nx    = m_st;
    fired = 1'b0;
    case (m_st)
      P_INIT:    nx = P_WAIT;
      P_WAIT:    if (start) nx = P_IDLE;
      P_IDLE:    if (tick) nx = P_REG;
      P_REG:     nx = P_COLLIDE;
      P_COLLIDE: if (collision_done || tmo) begin nx = P_APPLY; fired = !collision_done; end
      P_APPLY:   nx = (hp == 3'd0) ? P_OVER : P_MAP;
      P_MAP:     if (map_draw_done || tmo) begin nx = P_LINK; fired = !map_draw_done; end
      P_LINK:    if (link_draw_done || tmo) begin nx = P_IDLE; fired = !link_draw_done; m_fc++; end
      P_OVER:    if (start) nx = P_INIT;
      default:   nx = P_INIT;
    endcase
    if (m_st == P_INIT) begin
      m_ovr = 0; m_fc = '0; m_wdf = 0;
    end else begin
      if (tick && !(m_st inside {P_IDLE, P_WAIT, P_OVER})) m_ovr = 1;
      if (fired) m_wdf = 1;
    end
    m_dwell = (nx == m_st) ? m_dwell + 1 : 0;
    m_st    = nx;
  endtask

  function automatic logic [7:0] exp_strobes(input phase_t p);
    case (p)
      P_INIT:    return 8'b1000_0000;
      P_WAIT:    return 8'b0000_0000;
      P_IDLE:    return 8'b0100_0000;
      P_REG:     return 8'b0010_0000;
      P_COLLIDE: return 8'b0001_0000;
      P_APPLY:   return 8'b0000_1000;
      P_MAP:     return 8'b0000_0100;
      P_LINK:    return 8'b0000_0010;
      P_OVER:    return 8'b0000_0001;
      default:   return 8'hFF;
    endcase
  endfunction

  task automatic compare();
    logic [7:0] s;
    s = {init, idle, reg_action, check_collision, apply_action, draw_map, draw, game_over};
    check("strobes", {24'd0, s}, {24'd0, exp_strobes(m_st)});
    check("onehot", {31'd0, $countones(s) <= 1}, 32'd1);
    check("frame_overrun", {31'd0, frame_overrun}, {31'd0, m_ovr});
    check("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
`ifdef LINK_CONTROL_WATCHDOG_EN
    check("watchdog_fired", {31'd0, watchdog_fired}, {31'd0, m_wdf});
`endif
  endtask

  // Stimulus knobs, in percent.
  int p_start = 100, p_col = 100, p_map = 100, p_link = 100, p_hp0 = 0;

  task automatic step();
    start          = ($urandom_range(99) < p_start);
    collision_done = ($urandom_range(99) < p_col);
    map_draw_done  = ($urandom_range(99) < p_map);
    link_draw_done = ($urandom_range(99) < p_link);
    hp             = ($urandom_range(99) < p_hp0) ? 3'd0 : 3'($urandom_range(7, 1));
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 1'b0;
    compare();
  endtask

  initial begin
    int n;
    bit saw_map;

    // Basic frame with immediate done pulses.
    do_reset();
    check("reset_init", {31'd0, init}, 32'd1);
    check("reset_count", {16'd0, frame_count}, 32'd0);
    repeat (31) step();
    check("idle_before_tick", {31'd0, idle}, 32'd1);
    step();
    check("reg_after_tick", {31'd0, reg_action}, 32'd1);
    step();
    check("collide_next", {31'd0, check_collision}, 32'd1);
    repeat (4) step();
    check("first_frame_count", {16'd0, frame_count}, 32'd1);
    check("back_to_idle", {31'd0, idle}, 32'd1);

    // Link draw stalls across a tick: overrun, tick dropped.
    p_link = 0;
    repeat (70) step();
    check("overrun_set", {31'd0, frame_overrun}, 32'd1);
    check("stalled_in_draw", {31'd0, draw}, 32'd1);
    p_link = 100;
    step();
    check("second_frame_count", {16'd0, frame_count}, 32'd2);
    n = 0;
    while (!reg_action && n < 100) begin step(); n++; end
    check("next_frame_starts", {31'd0, reg_action}, 32'd1);

    // hp reaches zero: game over, no map draw, restart clears counters.
    p_hp0 = 100; p_start = 0; saw_map = 0; n = 0;
    while (!game_over && n < 100) begin step(); saw_map |= draw_map; n++; end
    check("game_over", {31'd0, game_over}, 32'd1);
    check("no_draw_map", {31'd0, saw_map}, 32'd0);
    p_start = 100; p_hp0 = 0;
    step();
    check("restart_init", {31'd0, init}, 32'd1);
    step();
    check("restart_count", {16'd0, frame_count}, 32'd0);
    check("restart_overrun", {31'd0, frame_overrun}, 32'd0);
    check("restart_init_gone", {31'd0, init}, 32'd0);

    // Reset in the middle of a map draw.
    p_map = 0; n = 0;
    while (!draw_map && n < 100) begin step(); n++; end
    check("reach_draw_map", {31'd0, draw_map}, 32'd1);
    do_reset();
    check("midreset_init", {31'd0, init}, 32'd1);
    check("midreset_draw_map", {31'd0, draw_map}, 32'd0);
    check("midreset_count", {16'd0, frame_count}, 32'd0);
    p_map = 100;

`ifdef LINK_CONTROL_WATCHDOG_EN
    // Collision detector never answers: forced exit after FC cycles.
    p_col = 0; n = 0;
    while (!check_collision && n < 100) begin step(); n++; end
    n = 0;
    while (check_collision && n < 100) begin step(); n++; end
    check("wd_dwell", n, FC);
    check("wd_apply", {31'd0, apply_action}, 32'd1);
    check("wd_fired", {31'd0, watchdog_fired}, 32'd1);
    p_col = 100;
`endif

    // Randomized segments with stray done pulses, stalls, hp=0 and resets.
    for (int seg = 0; seg < 40; seg++) begin
      p_start = $urandom_range(50);
      p_col   = $urandom_range(100, 5);
      p_map   = $urandom_range(100, 5);
      p_link  = $urandom_range(100, 3);
      p_hp0   = $urandom_range(25);
      if (seg % 10 == 9) do_reset();
      repeat (80) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
